// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg : shared types and defaults for the instruction sequencer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

  localparam int c_IW_DEFAULT    = 6;
  localparam int c_DEPTH_DEFAULT = 8;

  localparam logic [c_IW_DEFAULT-1:0] c_NOP = '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if : host/core-side signal bundle of the instruction sequencer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_sequencer_if
  import seq_pkg::*;
#(
  parameter int IW = c_IW_DEFAULT
);

  logic          wr_en;
  logic [IW-1:0] wr_data;
  logic          clear;
  logic          start;
  logic          stop;
  logic          loop;
  logic          stall;
  logic [IW-1:0] core_instr;
  logic          core_valid;
  logic          busy;
  logic          full;
  logic          done;

  modport master (
    output wr_en, wr_data, clear, start, stop, loop, stall,
    input  core_instr, core_valid, busy, full, done
  );

  modport slave (
    input  wr_en, wr_data, clear, start, stop, loop, stall,
    output core_instr, core_valid, busy, full, done
  );

endinterface : instr_sequencer_if

`default_nettype wire

// File: rtl/seq_buffer.sv
// ---------------------------------------------------------------------------
// seq_buffer : DEPTH x IW program store, one write port, one async read port
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seq_buffer
  import seq_pkg::*;
#(
  parameter int IW    = c_IW_DEFAULT,
  parameter int DEPTH = c_DEPTH_DEFAULT,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [IW-1:0] i_wdata,
  input  wire logic [AW-1:0] i_raddr,
  output      logic [IW-1:0] o_rdata
);

  // Storage is deliberately not reset: entries above the fill count are never read.
  logic [IW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : seq_buffer

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer : buffers a short program and plays it to a core, with stall/stop;
//                   optional wrap-around replay enabled by macro SEQ_LOOP_EN
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
  import seq_pkg::*;
#(
  parameter int IW    = c_IW_DEFAULT,
  parameter int DEPTH = c_DEPTH_DEFAULT
)(
  input  wire logic         clk,
  input  wire logic         rst,
  instr_sequencer_if.slave  bus
);

  localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW        = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
  localparam logic [IW-1:0]   c_NOP_W     = IW'(c_NOP);

  seq_state_e      r_state, w_state_nx;
  logic [c_CW-1:0] r_count, w_count_nx;
  // ptr shares the count width so the end-of-program test ptr==count also works when full.
  logic [c_CW-1:0] r_ptr,   w_ptr_nx;
  logic [IW-1:0]   r_instr, w_instr_nx;
  logic            r_valid, w_valid_nx;
  logic            r_done,  w_done_nx;

  logic            w_we;
  logic [c_AW-1:0] w_raddr;
  logic [IW-1:0]   w_rdata;
  logic            w_wrap;

`ifdef SEQ_LOOP_EN
  assign w_wrap = bus.loop;
`else
  logic w_loop_unused;
  assign w_loop_unused = bus.loop;
  assign w_wrap        = 1'b0;
`endif

  seq_buffer #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_count[c_AW-1:0]),
    .i_wdata (bus.wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ptr   <= '0;
      r_instr <= c_NOP_W;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_ptr   <= w_ptr_nx;
      r_instr <= w_instr_nx;
      r_valid <= w_valid_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_ptr_nx   = r_ptr;
    w_instr_nx = r_instr;
    w_valid_nx = r_valid;
    w_done_nx  = 1'b0;
    w_we       = 1'b0;
    w_raddr    = r_ptr[c_AW-1:0];

    unique case (r_state)
      IDLE: begin
        if (bus.clear) begin
          w_count_nx = '0;
        end else if (bus.start && (r_count != '0)) begin
          w_raddr    = '0;
          w_state_nx = RUN;
          w_instr_nx = w_rdata;
          w_valid_nx = 1'b1;
          w_ptr_nx   = c_ONE;
        end else if (bus.wr_en && (r_count < c_DEPTH_CNT)) begin
          w_we       = 1'b1;
          w_count_nx = r_count + c_ONE;
        end
      end

      RUN: begin
        if (bus.stop) begin
          w_state_nx = IDLE;
          w_instr_nx = c_NOP_W;
          w_valid_nx = 1'b0;
          w_ptr_nx   = '0;
        end else if (!bus.stall) begin
          if (r_ptr < r_count) begin
            w_instr_nx = w_rdata;
            w_ptr_nx   = r_ptr + c_ONE;
          end else if (w_wrap) begin
            w_raddr    = '0;
            w_instr_nx = w_rdata;
            w_ptr_nx   = c_ONE;
          end else begin
            w_state_nx = IDLE;
            w_instr_nx = c_NOP_W;
            w_valid_nx = 1'b0;
            w_ptr_nx   = '0;
            w_done_nx  = 1'b1;
          end
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.core_instr = r_instr;
  assign bus.core_valid = r_valid;
  assign bus.busy       = (r_state == RUN);
  assign bus.full       = (r_count == c_DEPTH_CNT);
  assign bus.done       = r_done;

endmodule : instr_sequencer

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer : scoreboard bench; expected program playback queued at start,
//                      checked by an independent negedge monitor
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int IW       = 6;
  localparam int DEPTH    = 8;
  localparam int c_DONE   = -1;
  localparam int c_BUDGET = 300;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_sequencer_if #(.IW(IW)) bus();

  instr_sequencer #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];   // expected core-side events: instruction values or c_DONE
  int prog[$];    // what the buffer should hold

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an instruction is consumed on a valid, non-stalled, non-stopped cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_vs_valid", int'(bus.busy), int'(bus.core_valid));
      if (!bus.core_valid) begin
        check("nop_when_invalid", int'(bus.core_instr), 0);
      end else if (!bus.stop) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr_qsize", exp_q.size(), 1);
        end else begin
          check("instr", int'(bus.core_instr), exp_q[0]);
          if (!bus.stall) void'(exp_q.pop_front());
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done_qsize", exp_q.size(), 1);
        end else begin
          check("done_order", exp_q[0], c_DONE);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_write(input int v);
    bus.wr_en   = 1'b1;
    bus.wr_data = IW'(v);
    tick();
    bus.wr_en   = 1'b0;
    if (prog.size() < DEPTH) prog.push_back(v);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    prog.delete();
  endtask

  task automatic drain(input bit rand_stall, input bit noise);
    for (int i = 0; i < c_BUDGET; i++) begin
      if (exp_q.size() == 0 && !bus.busy) break;
      bus.stall = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (noise && bus.busy) begin
        bus.wr_en   = 1'($urandom_range(0, 1));
        bus.wr_data = IW'($urandom);
        bus.clear   = ($urandom_range(0, 3) == 0);
        bus.start   = ($urandom_range(0, 3) == 0);
      end else begin
        bus.wr_en = 1'b0;
        bus.clear = 1'b0;
        bus.start = 1'b0;
      end
      tick();
    end
    bus.stall = 1'b0;
    bus.wr_en = 1'b0;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check("drain_qsize", exp_q.size(), 0);
    check("drain_busy", int'(bus.busy), 0);
    exp_q.delete();
  endtask

  task automatic run_prog(input bit rand_stall, input bit noise);
    foreach (prog[i]) exp_q.push_back(prog[i]);
    if (prog.size() > 0) exp_q.push_back(c_DONE);
`ifndef SEQ_LOOP_EN
    bus.loop = 1'($urandom_range(0, 1));
`endif
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain(rand_stall, noise);
    bus.loop = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clear   = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop    = 1'b0;
    bus.stall   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", int'(bus.core_valid), 0);
    check("rst_instr", int'(bus.core_instr), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_full",  int'(bus.full), 0);
    check("rst_done",  int'(bus.done), 0);

    // Basic three-instruction program
    do_write('h05); do_write('h0A); do_write('h13);
    run_prog(1'b0, 1'b0);
    // Replay without rewriting
    run_prog(1'b0, 1'b0);

    // Fill to capacity, ninth write dropped
    do_clear();
    for (int i = 0; i < DEPTH; i++) do_write(int'($urandom_range(0, 62)));
    check("full_at_depth", int'(bus.full), 1);
    do_write('h3F);
    check("full_after_overflow", int'(bus.full), 1);
    run_prog(1'b0, 1'b0);

    // Stall holds the first instruction for four cycles
    do_clear();
    do_write('h01); do_write('h02);
    exp_q.push_back('h01); exp_q.push_back('h02); exp_q.push_back(c_DONE);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stall = 1'b1;
    check("stall_hold_c1", int'(bus.core_instr), 'h01);
    tick();
    check("stall_hold_c2", int'(bus.core_instr), 'h01);
    tick();
    check("stall_hold_c3", int'(bus.core_instr), 'h01);
    tick();
    bus.stall = 1'b0;
    check("stall_hold_c4", int'(bus.core_instr), 'h01);
    tick();
    check("stall_release", int'(bus.core_instr), 'h02);
    drain(1'b0, 1'b0);

    // Stop mid-program, with stall also asserted
    do_clear();
    do_write('h11); do_write('h22); do_write('h33);
    exp_q.push_back('h11); exp_q.push_back('h22); exp_q.push_back('h33); exp_q.push_back(c_DONE);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("pre_stop_instr", int'(bus.core_instr), 'h22);
    bus.stop  = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.stall = 1'b0;
    exp_q.delete();
    check("stop_valid", int'(bus.core_valid), 0);
    check("stop_instr", int'(bus.core_instr), 0);
    check("stop_busy",  int'(bus.busy), 0);
    tick();
    run_prog(1'b0, 1'b0);

`ifdef SEQ_LOOP_EN
    // Looping playback, then stop
    do_clear();
    do_write('h11); do_write('h22);
    exp_q.push_back('h11); exp_q.push_back('h22);
    exp_q.push_back('h11); exp_q.push_back('h22); exp_q.push_back('h11);
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("loop_qsize", exp_q.size(), 0);
    check("loop_instr", int'(bus.core_instr), 'h22);
    check("loop_valid", int'(bus.core_valid), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    exp_q.delete();
    check("loop_stop_valid", int'(bus.core_valid), 0);
    check("loop_stop_instr", int'(bus.core_instr), 0);
    tick();
`endif

    // Start with an empty buffer is ignored
    do_clear();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("empty_start_busy", int'(bus.busy), 0);
    tick();
    check("empty_start_busy2", int'(bus.busy), 0);
    // clear wins over a simultaneous write
    bus.clear   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = IW'('h2A);
    tick();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    prog.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("clear_beats_wr_busy", int'(bus.busy), 0);

    // Reset while the second instruction is on the bus
    do_write('h07); do_write('h15); do_write('h2C);
    exp_q.push_back('h07); exp_q.push_back('h15); exp_q.push_back('h2C); exp_q.push_back(c_DONE);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("pre_rst_instr", int'(bus.core_instr), 'h15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    prog.delete();
    check("midrst_valid", int'(bus.core_valid), 0);
    check("midrst_instr", int'(bus.core_instr), 0);
    check("midrst_busy",  int'(bus.busy), 0);
    check("midrst_done",  int'(bus.done), 0);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("midrst_count_zero", int'(bus.busy), 0);

    // Randomized programs with random stalls and ignored writes/clears/starts in RUN
    for (int it = 0; it < 10; it++) begin
      do_clear();
      n = int'($urandom_range(1, DEPTH + 2));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) tick();
        do_write(int'($urandom_range(0, 63)));
      end
      check("rand_full", int'(bus.full), (prog.size() == DEPTH) ? 1 : 0);
      run_prog(1'b1, 1'b1);
      if (it % 2 == 0) run_prog(1'b1, 1'b0);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_instr_sequencer

`default_nettype wire
